layer_mem_arbiter: RTL

LAYER_MEM_ARBITER -- requirements
Module: layer_mem_arbiter

---
 rtl/layer_mem_arbiter_if.sv | 47 ++++
 rtl/layer_mem_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/layer_mem_arbiter_if.sv
// Requester and memory signal bundle for the layer-memory arbiter.
// The master side is the requesters plus memory; the slave side is the arbiter.
`timescale 1ns/1ps
interface layer_mem_arbiter_if #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 20
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [2:0]    sel0;
    logic [2:0]    sel1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          last0;
    logic          last1;
    logic          gnt0;
    logic          gnt1;
    logic          rvalid0;
    logic          rvalid1;
    logic [DW-1:0] rdata;
    logic          cwr;
    logic          crd;
    logic [2:0]    csel;
    logic [AW-1:0] caddr_wr;
    logic [AW-1:0] caddr_rd;
    logic [DW-1:0] cdata_wr;
    logic [DW-1:0] cdata_rd;
    logic          arb_busy;

    modport master (
        output req0, req1, we0, we1, sel0, sel1, addr0, addr1,
               wdata0, wdata1, last0, last1, cdata_rd,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, cwr, crd, csel,
               caddr_wr, caddr_rd, cdata_wr, arb_busy
    );

    modport slave (
        input  req0, req1, we0, we1, sel0, sel1, addr0, addr1,
               wdata0, wdata1, last0, last1, cdata_rd,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, cwr, crd, csel,
               caddr_wr, caddr_rd, cdata_wr, arb_busy
    );
endinterface

// File: rtl/layer_mem_arbiter.sv
// Two-requester round-robin burst arbiter in front of a banked layer memory.
// Memory strobes are registered one cycle after acceptance; read data returns one cycle later.
`timescale 1ns/1ps
module layer_mem_arbiter #(
    parameter int unsigned AW        = 12,
    parameter int unsigned DW        = 20,
    parameter int unsigned BURST_MAX = 16
) (
    input logic               clk,
    input logic               reset,
    layer_mem_arbiter_if.slave bus
);
    localparam int unsigned CW = $clog2(BURST_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          prio;
    logic          prio_nxt;
    logic [CW-1:0] burst_cnt;
    logic [CW-1:0] burst_cnt_nxt;

    logic          acc;
    logic          acc_id;
    logic          acc_we;
    logic          acc_last;
    logic [2:0]    acc_sel;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;
    logic          rd_tag;

    // Fields of the currently granted requester; acc marks an accepted transfer.
    always_comb begin
        acc_id    = (state == OWN1);
        acc       = ((state == OWN0) && bus.req0) || ((state == OWN1) && bus.req1);
        acc_we    = acc_id ? bus.we1    : bus.we0;
        acc_last  = acc_id ? bus.last1  : bus.last0;
        acc_sel   = acc_id ? bus.sel1   : bus.sel0;
        acc_addr  = acc_id ? bus.addr1  : bus.addr0;
        acc_wdata = acc_id ? bus.wdata1 : bus.wdata0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            prio      <= 1'b0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            prio      <= prio_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    // Grants always pass through IDLE, so a requester change costs one idle cycle.
    always_comb begin
        state_nxt     = state;
        prio_nxt      = prio;
        burst_cnt_nxt = burst_cnt;
        case (state)
            IDLE: begin
                burst_cnt_nxt = '0;
                if (bus.req0 && bus.req1) begin
                    state_nxt = prio ? OWN1 : OWN0;
                end else if (bus.req0) begin
                    state_nxt = OWN0;
                end else if (bus.req1) begin
                    state_nxt = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (!acc || acc_last || (burst_cnt == CW'(BURST_MAX - 1))) begin
                    state_nxt = IDLE;
                    prio_nxt  = ~acc_id;
                end else begin
                    burst_cnt_nxt = burst_cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered grants, memory strobes and the read-return pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.gnt0     <= 1'b0;
            bus.gnt1     <= 1'b0;
            bus.cwr      <= 1'b0;
            bus.crd      <= 1'b0;
            bus.csel     <= '0;
            bus.caddr_wr <= '0;
            bus.caddr_rd <= '0;
            bus.cdata_wr <= '0;
            bus.rvalid0  <= 1'b0;
            bus.rvalid1  <= 1'b0;
            bus.rdata    <= '0;
            bus.arb_busy <= 1'b0;
            rd_tag       <= 1'b0;
        end else begin
            bus.gnt0 <= (state_nxt == OWN0);
            bus.gnt1 <= (state_nxt == OWN1);
            bus.cwr  <= acc && acc_we;
            bus.crd  <= acc && !acc_we;
            if (acc) begin
                bus.csel <= acc_sel;
            end
            if (acc && acc_we) begin
                bus.caddr_wr <= acc_addr;
                bus.cdata_wr <= acc_wdata;
            end
            if (acc && !acc_we) begin
                bus.caddr_rd <= acc_addr;
                rd_tag       <= acc_id;
            end
            // Tag travels with the read so rvalid follows the issuer, not the current grant.
            bus.rvalid0 <= bus.crd && !rd_tag;
            bus.rvalid1 <= bus.crd && rd_tag;
            if (bus.crd) begin
                bus.rdata <= bus.cdata_rd;
            end
            bus.arb_busy <= (state_nxt != IDLE) || (acc && !acc_we) || bus.crd;
        end
    end
endmodule
